// File: rtl/debam_pkg.sv
// Shared definitions for the DeBAM product accumulator: the controller state
// encoding, the term-count width helper and the parameter legality rules.
package debam_pkg;

    // ACCUM collects terms; HOLD presents a finished frame until it drains.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // The count must reach MAX_TERMS itself, so it needs one bit more than
    // $clog2 alone provides for exact powers of two.
    function automatic int count_w(input int max_terms);
        return $clog2(max_terms) + 1;
    endfunction

    // The accumulator must be able to hold at least one full product.
    function automatic bit acc_w_legal(input int n, input int acc_w);
        return acc_w >= 2 * n;
    endfunction

    // A frame always contains at least one term.
    function automatic bit max_terms_legal(input int max_terms);
        return max_terms >= 1;
    endfunction

endpackage

// File: rtl/debam_sat_add.sv
// Unsigned saturating adder: a carry out of the top bit clamps the result to
// all ones and raises sat for the same cycle.
module debam_sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] full;

    // One bit wider than the operands so the carry is observable.
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        sat  = full[W];
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/debam_product_accumulator.sv
// Frame-based MAC accumulator placed directly after the DeBAM multiplier.
// Products arrive one per accepted beat, are summed with saturation, and the
// finished frame (sum, term count, sticky overflow) is presented on a
// one-entry registered output.
//
// Handshake: a beat is transferred on a rising edge where IN_VALID and
// IN_READY are both high; a result is transferred where OUT_VALID and
// OUT_READY are both high. Payloads are only sampled on a transfer, and a
// valid without ready changes nothing. IN_READY is combinational from the
// state and OUT_READY so a draining result can be replaced in the same cycle.
module debam_product_accumulator
    import debam_pkg::*;
#(
    parameter int N         = 8,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [2*N-1:0]                 PRODUCT,
    input  logic                           IN_LAST,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [ACC_W-1:0]               ACC_OUT,
    output logic [count_w(MAX_TERMS)-1:0]  TERM_COUNT,
    output logic                           OVERFLOW
);

    localparam int CW = count_w(MAX_TERMS);

    if (!acc_w_legal(N, ACC_W)) begin : g_bad_acc_w
        $error("debam_product_accumulator: ACC_W must be at least 2*N");
    end
    if (!max_terms_legal(MAX_TERMS)) begin : g_bad_max_terms
        $error("debam_product_accumulator: MAX_TERMS must be at least 1");
    end

    state_e          state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    count;
    logic             ovf;

    logic             accept;
    logic             frame_end;
    logic [ACC_W-1:0] product_ext;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic [CW-1:0]    next_count;

    // Ready whenever collecting, or when the held result drains this cycle.
    assign IN_READY = (state == ACCUM) || ((state == HOLD) && OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    // Internal acc/count/ovf are cleared when a frame closes, so a beat taken
    // while in HOLD naturally starts the next frame from zero.
    assign product_ext = ACC_W'(PRODUCT);
    assign next_count  = count + CW'(1);
    assign frame_end   = IN_LAST || (next_count == CW'(MAX_TERMS));

    debam_sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc),
        .b   (product_ext),
        .sum (sum),
        .sat (sat)
    );

    // Controller, running accumulator and result registers: drain first,
    // then let an accepted beat either extend the frame or close it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ACCUM;
            acc        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            OUT_VALID  <= 1'b0;
            ACC_OUT    <= '0;
            TERM_COUNT <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            if ((state == HOLD) && OUT_READY) begin
                OUT_VALID <= 1'b0;
                state     <= ACCUM;
            end
            if (accept) begin
                if (frame_end) begin
                    ACC_OUT    <= sum;
                    TERM_COUNT <= next_count;
                    OVERFLOW   <= ovf | sat;
                    OUT_VALID  <= 1'b1;
                    state      <= HOLD;
                    acc        <= '0;
                    count      <= '0;
                    ovf        <= 1'b0;
                end else begin
                    acc   <= sum;
                    count <= next_count;
                    ovf   <= ovf | sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_debam_product_accumulator.sv
// Bench for debam_product_accumulator: three instances cover the default
// configuration, a narrow saturating accumulator and a tiny MAX_TERMS.
module tb_debam_product_accumulator;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid  [NI];
    logic [15:0] product   [NI];
    logic        in_last   [NI];
    logic        out_ready [NI];

    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] overflow;
    logic [23:0]   acc0, acc2;
    logic [15:0]   acc1;
    logic [8:0]    tc0, tc1;
    logic [2:0]    tc2;
    logic [31:0]   d_acc [NI];
    logic [31:0]   d_tc  [NI];

    assign d_acc[0] = 32'(acc0);
    assign d_acc[1] = 32'(acc1);
    assign d_acc[2] = 32'(acc2);
    assign d_tc[0]  = 32'(tc0);
    assign d_tc[1]  = 32'(tc1);
    assign d_tc[2]  = 32'(tc2);

    debam_product_accumulator #(.N(8), .ACC_W(24), .MAX_TERMS(256)) u_main (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .PRODUCT(product[0]), .IN_LAST(in_last[0]), .OUT_VALID(out_valid[0]),
        .OUT_READY(out_ready[0]), .ACC_OUT(acc0), .TERM_COUNT(tc0), .OVERFLOW(overflow[0])
    );

    debam_product_accumulator #(.N(8), .ACC_W(16), .MAX_TERMS(256)) u_sat (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .PRODUCT(product[1]), .IN_LAST(in_last[1]), .OUT_VALID(out_valid[1]),
        .OUT_READY(out_ready[1]), .ACC_OUT(acc1), .TERM_COUNT(tc1), .OVERFLOW(overflow[1])
    );

    debam_product_accumulator #(.N(8), .ACC_W(24), .MAX_TERMS(4)) u_frc (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
        .PRODUCT(product[2]), .IN_LAST(in_last[2]), .OUT_VALID(out_valid[2]),
        .OUT_READY(out_ready[2]), .ACC_OUT(acc2), .TERM_COUNT(tc2), .OVERFLOW(overflow[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each frame is an unbounded integer sum of its terms;
    // the presented value is that sum clamped to the accumulator range, and
    // overflow means the true sum did not fit.
    longint wmax [NI];
    int     maxt [NI];
    logic   m_hold [NI];
    longint m_acc  [NI];
    longint m_tc   [NI];
    logic   m_ovf  [NI];
    longint f_sum  [NI];
    longint f_cnt  [NI];

    initial begin
        bit rdy;
        wmax[0] = (64'd1 << 24) - 1; maxt[0] = 256;
        wmax[1] = (64'd1 << 16) - 1; maxt[1] = 256;
        wmax[2] = (64'd1 << 24) - 1; maxt[2] = 4;
        for (int k = 0; k < NI; k++) begin
            m_hold[k] = 1'b0; m_acc[k] = 0; m_tc[k] = 0; m_ovf[k] = 1'b0;
            f_sum[k] = 0; f_cnt[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < NI; k++) begin
                if (rst) begin
                    m_hold[k] = 1'b0; m_acc[k] = 0; m_tc[k] = 0; m_ovf[k] = 1'b0;
                    f_sum[k] = 0; f_cnt[k] = 0;
                end else begin
                    rdy = !m_hold[k] || out_ready[k];
                    if (m_hold[k] && out_ready[k]) m_hold[k] = 1'b0;
                    if (in_valid[k] && rdy) begin
                        f_sum[k] += longint'(product[k]);
                        f_cnt[k] += 1;
                        if (in_last[k] || f_cnt[k] == maxt[k]) begin
                            m_acc[k]  = (f_sum[k] > wmax[k]) ? wmax[k] : f_sum[k];
                            m_ovf[k]  = (f_sum[k] > wmax[k]);
                            m_tc[k]   = f_cnt[k];
                            m_hold[k] = 1'b1;
                            f_sum[k]  = 0;
                            f_cnt[k]  = 0;
                        end
                    end
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_hold[k]));
                chk($sformatf("in_ready[%0d]", k), 64'(in_ready[k]),
                    64'(!m_hold[k] || out_ready[k]));
                if (m_hold[k]) begin
                    chk($sformatf("acc_out[%0d]", k), 64'(d_acc[k]), 64'(m_acc[k]));
                    chk($sformatf("term_count[%0d]", k), 64'(d_tc[k]), 64'(m_tc[k]));
                    chk($sformatf("overflow[%0d]", k), 64'(overflow[k]), 64'(m_ovf[k]));
                end
            end
        end
    end

    // Present one beat, let the next rising edge take it, then go idle.
    task automatic beat(input int k, input int p, input bit last);
        in_valid[k] = 1'b1;
        product[k]  = 16'(p);
        in_last[k]  = last;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic chk_result(input string name, input int k, input int a, input int t, input bit o);
        chk({name, " valid"}, 64'(out_valid[k]), 64'd1);
        chk({name, " acc"}, 64'(d_acc[k]), 64'(a));
        chk({name, " count"}, 64'(d_tc[k]), 64'(t));
        chk({name, " ovf"}, 64'(overflow[k]), 64'(o));
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; product[k] = '0; in_last[k] = 1'b0; out_ready[k] = 1'b1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset valid %0d", k), 64'(out_valid[k]), 64'd0);
            chk($sformatf("reset acc %0d", k), 64'(d_acc[k]), 64'd0);
            chk($sformatf("reset count %0d", k), 64'(d_tc[k]), 64'd0);
            chk($sformatf("reset ovf %0d", k), 64'(overflow[k]), 64'd0);
        end
        rst = 1'b0;

        // Basic three-term frame.
        beat(0, 100, 0); beat(0, 200, 0); beat(0, 300, 1);
        chk_result("basic", 0, 600, 3, 0);

        // Saturation in a 16-bit accumulator, then a clean single-term frame
        // that replaces the draining result in the same cycle.
        beat(1, 65025, 0); beat(1, 65025, 1);
        chk_result("sat", 1, 65535, 2, 1);
        beat(1, 5, 1);
        chk_result("after_sat", 1, 5, 1, 0);

        // Backpressure: result held while a blocked beat waits.
        beat(0, 7, 0);
        out_ready[0] = 1'b0;
        beat(0, 9, 1);
        in_valid[0] = 1'b1; product[0] = 16'd99; in_last[0] = 1'b0;
        repeat (5) begin
            chk("bp in_ready", 64'(in_ready[0]), 64'd0);
            chk_result("bp hold", 0, 16, 2, 0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        #1;
        chk("bp release ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("bp drained", 64'(out_valid[0]), 64'd0);
        beat(0, 1, 1);
        chk_result("bp next", 0, 100, 2, 0);

        // Back-to-back frames with no idle cycles.
        beat(0, 1, 0); beat(0, 2, 1);
        chk_result("b2b f1", 0, 3, 2, 0);
        beat(0, 3, 1);
        chk_result("b2b f2", 0, 3, 1, 0);
        beat(0, 4, 0);
        chk("b2b gap", 64'(out_valid[0]), 64'd0);
        beat(0, 4, 1);
        chk_result("b2b f3", 0, 8, 2, 0);

        // Forced termination at four terms; two more terms stay pending.
        repeat (4) beat(2, 10, 0);
        chk_result("forced", 2, 40, 4, 0);
        beat(2, 10, 0); beat(2, 10, 0); beat(2, 0, 1);
        chk_result("forced tail", 2, 20, 3, 0);

        // Asynchronous reset in the middle of a frame.
        beat(0, 50, 0); beat(0, 60, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("rst valid", 64'(out_valid[0]), 64'd0);
        chk("rst acc", 64'(d_acc[0]), 64'd0);
        chk("rst count", 64'(d_tc[0]), 64'd0);
        chk("rst ovf", 64'(overflow[0]), 64'd0);
        #1;
        rst = 1'b0;
        beat(0, 1, 1);
        chk_result("post rst", 0, 1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
